adiabatic_inv_pipe: RTL and testbench
=====================================

# adiabatic_inv_pipe

Parametrised, clocked behavioural model of a WIDTH-bit, STAGES-deep adiabatic inverter pipeline driven by a four-phase power clock. Each stage inverts its predecessor's held value. A stage's node is charged during its EVAL phase, held for one HOLD cycle, and returned to zero (recovered) afterwards. The block sits in the adder datapath verification flow as the cycle-level golden model of cascaded inverter stages. It also generates the per-stage phase information that the switch-level cells consume.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- STAGES, 4, number of cascaded inverter stages (1..16)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  power-clock enable; low freezes phase and all stage nodes
- in_valid  in  1  input word offered
- in_data  in  WIDTH  input word
- in_ready  out  1  high when stage 0 is in EVAL (phase==0)
- out_valid  out  1  last stage holds a valid word
- out_data  out  WIDTH  last stage node value; 0 when out_valid low
- phase  out  2  global power-clock phase: 0 EVAL, 1 HOLD, 2 RECOVER, 3 WAIT
- stage_hold  out  STAGES  bit k high while stage k is in HOLD
- recov_cnt  out  16  recovered-charge counter (see Configuration)

## Operation
- Global phase counter `ph` increments mod 4 on each edge with en=1.
- Stage k phase = (ph − k) mod 4. Stage k is in EVAL exactly when its predecessor is in HOLD.
- Per stage registers: val[k] (1 bit) and dat[k] (WIDTH bits). These are nonzero only during the stage's HOLD cycle.
- At an edge where en=1 and stage k is in EVAL:
  - Stage 0: val[0] <= in_valid, dat[0] <= in_valid ? ~in_data : 0.
  - Stage k≥1: val[k] <= val[k−1], dat[k] <= val[k−1] ? ~dat[k−1] : 0.
- At an edge where en=1 and stage k is in HOLD: val[k], dat[k] <= 0 (recovery).
- RECOVER and WAIT edges leave val/dat at 0.
- A transfer occurs when in_valid && in_ready at an edge. There is no backpressure: out has no ready, and a word not taken in its HOLD cycle is lost.
- out_valid = val[STAGES−1] and out_data = dat[STAGES−1].
- Output polarity: out_data = in_data if STAGES is even, ~in_data if odd.
- stage_hold[k] = (((ph − k) mod 4) == 1). This output is combinational from ph.
- Throughput is at most one word per 4 cycles. When STAGES>4, stages k and k+4 share a phase and carry different words concurrently.

## Timing
- Reset values after the rst edge:
  - ph=0, all val/dat=0, recov_cnt=0.
  - in_ready=1, out_valid=0, out_data=0, phase=0.
  - stage_hold has bit k set for all k≡3 mod 4.
- rst has priority over en.
- rst mid-flight discards all in-flight words. out_valid is 0 from the cycle after the rst edge.
- Latency: for a word sampled at edge t, stage k is valid during the cycle between edges t+k and t+k+1. out_valid is high for exactly one cycle, between edges t+STAGES−1 and t+STAGES.
- en=0: ph, val, dat and recov_cnt all hold, and outputs are unchanged. This can extend a HOLD cycle indefinitely. Resuming with en=1 continues from the frozen phase.
- in_valid while in_ready=0 is ignored, with no sticky capture.
- STAGES=1: the word is sampled at the ph=0 edge and visible while ph=1.

## Configuration
- `ADIABATIC_INV_RECOV_CNT_EN` defined:
  - recov_cnt is a 16-bit counter.
  - At each edge with en=1 it adds the popcount of dat[k] for every stage k in HOLD with val[k]=1, summed over all such stages.
  - The counter saturates at 0xFFFF and is cleared by rst.
- Not defined: recov_cnt is tied to 0 and no counter logic is built.

## Test plan
- WIDTH=8, STAGES=4: rst, then in_valid=1, in_data=0xA5 at the first ph=0 edge → out_valid=1 with out_data=0xA5 for exactly the one cycle after edge 3. out_data=0 in all other cycles.
- STAGES=3, in_data=0x3C accepted at a ph=0 edge → out_data=0xC3 in the single out_valid cycle, two cycles after the stage-0 HOLD cycle.
- in_valid=1 held through ph=1..3 with data 0x11 → nothing is accepted until ph=0. Back-to-back words 0x01, 0x02 presented at successive ph=0 edges → each word is output 4 cycles apart, with polarity per STAGES.
- en dropped to 0 during stage 1's HOLD for 5 cycles → dat[1] and ph are frozen and stage_hold is constant. After en returns to 1, the word emerges 5 cycles later than nominal with the correct value.
- rst asserted while a word is in stage 2 → all stage registers are cleared and out_valid never pulses for that word. in_ready=1 in the cycle after the rst edge.
- With the macro defined, STAGES=4, in_data=0xFF → recov_cnt=16 after the word fully recovers. With the counter preset near saturation, further words leave recov_cnt=0xFFFF. Without the macro, recov_cnt=0 throughout.

Source files
------------

// File: rtl/adiabatic_inv_pipe.sv
// rtl/adiabatic_inv_pipe.sv - cycle-level adiabatic inverter pipeline on a four-phase power clock
// Optional feature macro: ADIABATIC_INV_RECOV_CNT_EN (recovered-charge counter on recov_cnt).
module adiabatic_inv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        phase,
  output logic [STAGES-1:0] stage_hold,
  output logic [15:0]       recov_cnt
);

  // Global power-clock phase: 0 EVAL, 1 HOLD, 2 RECOVER, 3 WAIT
  logic [1:0] ph;

  // Per-stage node state; nonzero only while that stage is in HOLD
  logic [STAGES-1:0]            val;
  logic [STAGES-1:0][WIDTH-1:0] dat;

  // Local phase of each stage and the value offered by its predecessor
  logic [1:0]                   sph [STAGES];
  logic [STAGES-1:0]            up_val;
  logic [STAGES-1:0][WIDTH-1:0] up_dat;

  // Stage k lags the global phase by k, so it evaluates while stage k-1 holds
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sph[k] = ph - 2'(k);
    end
  end

  // Stage 0 is fed from the input port, every later stage from its predecessor's node
  always_comb begin
    up_val    = '0;
    up_dat    = '0;
    up_val[0] = in_valid;
    up_dat[0] = in_data;
    for (int k = 1; k < STAGES; k++) begin
      up_val[k] = val[k-1];
      up_dat[k] = dat[k-1];
    end
  end

  // HOLD indicator per stage, derived directly from the global phase
  always_comb begin
    stage_hold = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_hold[k] = (sph[k] == 2'd1);
    end
  end

  assign in_ready  = (ph == 2'd0);
  assign phase     = ph;
  assign out_valid = val[STAGES-1];
  assign out_data  = dat[STAGES-1];

  // Phase advance plus charge (EVAL) and recovery (every other phase) of each stage node
  always_ff @(posedge clk) begin
    if (rst) begin
      ph  <= 2'd0;
      val <= '0;
      dat <= '0;
    end else if (en) begin
      ph <= ph + 2'd1;
      for (int k = 0; k < STAGES; k++) begin
        if (sph[k] == 2'd0) begin
          val[k] <= up_val[k];
          dat[k] <= up_val[k] ? ~up_dat[k] : '0;
        end else begin
          // HOLD ends in recovery; RECOVER and WAIT simply keep the node discharged
          val[k] <= 1'b0;
          dat[k] <= '0;
        end
      end
    end
  end

`ifdef ADIABATIC_INV_RECOV_CNT_EN
  logic [15:0] cnt;
  logic [31:0] add;
  logic [32:0] tot;

  // Charge returned this edge: set bits of every valid node that is leaving HOLD
  always_comb begin
    add = '0;
    for (int k = 0; k < STAGES; k++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (sph[k] == 2'd1 && val[k] && dat[k][b]) begin
          add = add + 32'd1;
        end
      end
    end
    tot = {17'd0, cnt} + {1'b0, add};
  end

  // Saturating accumulator of recovered charge, frozen while the power clock is stopped
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (|tot[32:16]) ? 16'hFFFF : tot[15:0];
    end
  end

  assign recov_cnt = cnt;
`else
  assign recov_cnt = '0;
`endif

endmodule

// File: tb/tb_adiabatic_inv_pipe.sv
// tb/tb_adiabatic_inv_pipe.sv - self-checking bench for adiabatic_inv_pipe (STAGES=4 and STAGES=3 instances)
module tb_adiabatic_inv_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, in_valid;
  logic [7:0] in_data;

  logic       r4, v4, r3, v3;
  logic [7:0] d4, d3;
  logic [1:0] p4, p3;
  logic [3:0] sh4;
  logic [2:0] sh3;
  logic [15:0] rc4, rc3;

  adiabatic_inv_pipe #(.WIDTH(8), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r4), .out_valid(v4), .out_data(d4), .phase(p4),
    .stage_hold(sh4), .recov_cnt(rc4)
  );

  adiabatic_inv_pipe #(.WIDTH(8), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r3), .out_valid(v3), .out_data(d3), .phase(p3),
    .stage_hold(sh3), .recov_cnt(rc3)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Behavioural model: E counts enabled edges since reset; each accepted word
  // remembers the value of E just after its acceptance, so its age is E-acc+1.
  int         E = 0;
  bit         started = 0;
  logic [7:0] wd[$];
  int         we[$];
  int         cnt4 = 0, cnt3 = 0;

  function automatic int age_of(int i);
    return E - we[i] + 1;
  endfunction

  // A word of age a sits in stage a-1, inverted a times
  function automatic logic [7:0] word_at(int a, logic [7:0] w);
    return (a % 2 == 1) ? ~w : w;
  endfunction

  function automatic logic exp_valid(int s);
    for (int i = 0; i < wd.size(); i++) if (age_of(i) == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_data(int s);
    for (int i = 0; i < wd.size(); i++) if (age_of(i) == s) return word_at(s, wd[i]);
    return 8'h00;
  endfunction

  function automatic logic [31:0] exp_hold(int s);
    logic [31:0] r = 0;
    for (int k = 0; k < s; k++) if ((((E - k) % 4) + 4) % 4 == 1) r[k] = 1'b1;
    return r;
  endfunction

  function automatic int recov_add(int c, int s);
    int t = c;
    for (int i = 0; i < wd.size(); i++) begin
      if (age_of(i) >= 1 && age_of(i) <= s) t += $countones(word_at(age_of(i), wd[i]));
    end
    return (t > 65535) ? 65535 : t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      E = 0;
      wd.delete();
      we.delete();
      cnt4 = 0;
      cnt3 = 0;
      started = 1;
    end else if (en) begin
      cnt4 = recov_add(cnt4, 4);
      cnt3 = recov_add(cnt3, 3);
      if (in_valid && (E % 4 == 0)) begin
        wd.push_back(in_data);
        we.push_back(E + 1);
      end
      E++;
      while (we.size() > 0 && (E - we[0] + 1) > 16) begin
        void'(wd.pop_front());
        void'(we.pop_front());
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      chk("d4_in_ready",  r4,  (E % 4 == 0));
      chk("d4_phase",     p4,  E % 4);
      chk("d4_stage_hold", sh4, exp_hold(4));
      chk("d4_out_valid", v4,  exp_valid(4));
      chk("d4_out_data",  d4,  exp_data(4));
      chk("d3_in_ready",  r3,  (E % 4 == 0));
      chk("d3_stage_hold", sh3, exp_hold(3));
      chk("d3_out_valid", v3,  exp_valid(3));
      chk("d3_out_data",  d3,  exp_data(3));
`ifdef ADIABATIC_INV_RECOV_CNT_EN
      chk("d4_recov_cnt", rc4, cnt4);
      chk("d3_recov_cnt", rc3, cnt3);
`else
      chk("d4_recov_cnt", rc4, 0);
      chk("d3_recov_cnt", rc3, 0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    int n = 0;
    while (p4 != p && n < 8) begin
      cyc();
      n++;
    end
    chk("wait_phase", p4, p);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] fp;
    logic [3:0] fh;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) cyc();
    chk("rst_in_ready",   r4,  1);
    chk("rst_phase",      p4,  0);
    chk("rst_hold4",      sh4, 4'b1000);
    chk("rst_hold3",      sh3, 3'b000);
    chk("rst_out_valid",  v4,  0);
    chk("rst_out_data",   d4,  0);
    chk("rst_recov",      rc4, 0);

    // 0xA5 at the first ph=0 edge
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    cyc();
    in_valid = 1'b0;
    chk("a5_e0_v4", v4, 0);
    cyc();
    cyc();
    chk("a5_e2_v3", v3, 1);
    chk("a5_e2_d3", d3, 8'h5A);
    chk("a5_e2_v4", v4, 0);
    cyc();
    chk("a5_e3_v4", v4, 1);
    chk("a5_e3_d4", d4, 8'hA5);
    chk("a5_e3_d3", d3, 8'h00);
    cyc();
    chk("a5_e4_v4", v4, 0);
    chk("a5_e4_d4", d4, 8'h00);

    // odd depth inverts
    wait_phase(2'd0);
    in_valid = 1'b1; in_data = 8'h3C;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("3c_v3", v3, 1);
    chk("3c_d3", d3, 8'hC3);

    // offers outside ph=0 are ignored, then back-to-back words
    wait_phase(2'd1);
    in_valid = 1'b1; in_data = 8'h11;
    repeat (3) cyc();
    chk("b2b_ready", r4, 1);
    in_data = 8'h01;
    cyc();
    in_data = 8'h02;
    cyc();
    cyc();
    chk("b2b_d3_first", d3, 8'hFE);
    cyc();
    chk("b2b_d4_first", d4, 8'h01);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("b2b_d3_second", d3, 8'hFD);
    cyc();
    chk("b2b_d4_second", d4, 8'h02);

    // power clock frozen while stage 1 holds
    wait_phase(2'd0);
    in_valid = 1'b1; in_data = 8'h5E;
    cyc();
    in_valid = 1'b0;
    cyc();
    en = 1'b0;
    fp = p4;
    fh = sh4;
    repeat (5) begin
      cyc();
      chk("frz_phase", p4, fp);
      chk("frz_hold", sh4, fh);
      chk("frz_v4", v4, 0);
    end
    en = 1'b1;
    cyc();
    chk("frz_late_v4", v4, 0);
    cyc();
    chk("frz_out_v4", v4, 1);
    chk("frz_out_d4", d4, 8'h5E);

    // reset while a word sits in stage 2
    wait_phase(2'd0);
    in_valid = 1'b1; in_data = 8'h77;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("mid_rst_ready", r4, 1);
    chk("mid_rst_v4", v4, 0);
    rst = 1'b0;
    repeat (6) begin
      cyc();
      chk("mid_rst_no_out", v4, 0);
    end

    // randomized traffic against the model
    repeat (3000) begin
      en       = ($urandom % 8) != 0;
      in_valid = $urandom % 2;
      in_data  = 8'($urandom);
      rst      = ($urandom % 150) == 0;
      cyc();
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    repeat (8) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
